pss_burst_gen: RTL and testbench

- Transmit-side counterpart of the PSS detection chain. Generates the 127-symbol NR PSS sequence d(n) for a selected N_id_2 as BPSK IQ subcarrier values.
- Output is an AXI-stream burst. The source is a one-shot start or an internal periodic SSB timer.
- Used as the stimulus source for loopback of the correlator/peak-detector path and as the PSS mapper input of the TX frequency-domain chain.

---
 rtl/pss_burst_gen.sv | 128 ++++++++++++
 tb/tb_pss_burst_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pss_burst_gen.sv
// NR PSS burst source: emits the 127-symbol BPSK d(n) for a chosen N_id_2 as an AXI-stream burst,
// launched by start_i or by an internal periodic timer. States: IDLE | waiting; SEED | pre-rolling LFSR 43*N_id_2 steps; RUN | streaming symbols.
module pss_burst_gen #(
    parameter int OUT_DW    = 32,
    parameter int AMPLITUDE = 2**(OUT_DW/2-1)-1,
    parameter int PERIOD_W  = 16,
    parameter int PSS_SYMS  = 127
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [1:0]          N_id_2_i,
    input  logic                periodic_en_i,
    input  logic [PERIOD_W-1:0] period_i,
    output logic [OUT_DW-1:0]   m_axis_out_tdata,
    output logic                m_axis_out_tvalid,
    input  logic                m_axis_out_tready,
    output logic                m_axis_out_tlast,
    output logic                busy_o,
    output logic                err_o,
    output logic                overrun_o
);
    localparam int HW = OUT_DW/2;
    localparam logic [HW-1:0] I_POS = HW'(AMPLITUDE);
    localparam logic [HW-1:0] I_NEG = HW'(-AMPLITUDE);
    localparam logic [6:0] LFSR_INIT = 7'b1110110;
    localparam logic [6:0] LAST_SYM = 7'(PSS_SYMS-1);

    typedef enum logic [1:0] {IDLE, SEED, RUN} state_t;
    state_t state_q, state_d;

    logic [6:0]          lfsr_q, lfsr_next, sym_cnt_q, seed_cnt_q, seed_len;
    logic [1:0]          nid_q, nid_sel;
    logic [PERIOD_W-1:0] per_cnt_q;
    logic                per_done_q, pending_q, err_q, overrun_q;
    logic                start_ok, per_fire, launch, beat, last_beat;

    // lfsr_q[k] holds x(i+k); x(i) is the symbol currently presented
    assign lfsr_next = {lfsr_q[4] ^ lfsr_q[0], lfsr_q[6:1]};
    assign beat      = (state_q == RUN) && m_axis_out_tready;
    assign last_beat = beat && (sym_cnt_q == LAST_SYM);
    assign per_fire  = periodic_en_i && (period_i != '0) && !per_done_q &&
                       (per_cnt_q == period_i - PERIOD_W'(1));

    always_comb begin
        state_d  = state_q;
        launch   = 1'b0;
        start_ok = 1'b0;
        nid_sel  = nid_q;
        case (state_q)
            IDLE: begin
                start_ok = start_i && (N_id_2_i != 2'd3);
                if (start_ok || pending_q || per_fire) begin
                    launch  = 1'b1;
                    nid_sel = start_ok ? N_id_2_i : nid_q;
                    state_d = (nid_sel == 2'd0) ? RUN : SEED;
                end
            end
            SEED:    if (seed_cnt_q == 7'd1) state_d = RUN;
            RUN:     if (last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (nid_sel)
            2'd1:    seed_len = 7'd43;
            2'd2:    seed_len = 7'd86;
            default: seed_len = 7'd0;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lfsr_q     <= '0;
            sym_cnt_q  <= '0;
            seed_cnt_q <= '0;
            nid_q      <= '0;
        end else if (launch) begin
            lfsr_q     <= LFSR_INIT;
            sym_cnt_q  <= '0;
            seed_cnt_q <= seed_len;
            nid_q      <= nid_sel;
        end else if (state_q == SEED) begin
            lfsr_q     <= lfsr_next;
            seed_cnt_q <= seed_cnt_q - 7'd1;
        end else if (beat) begin
            lfsr_q     <= lfsr_next;
            sym_cnt_q  <= sym_cnt_q + 7'd1;
        end
    end

    // Period timer fires once per launch, then holds until the next launch
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            per_cnt_q  <= '0;
            per_done_q <= 1'b0;
            pending_q  <= 1'b0;
            err_q      <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (launch) begin
                per_cnt_q  <= '0;
                per_done_q <= 1'b0;
            end else if (per_fire) begin
                per_done_q <= 1'b1;
            end else if (!per_done_q && (per_cnt_q != '1)) begin
                per_cnt_q  <= per_cnt_q + PERIOD_W'(1);
            end
            if (!periodic_en_i || launch) pending_q <= 1'b0;
            else if (per_fire)            pending_q <= 1'b1;
            err_q     <= (state_q == IDLE) && start_i && (N_id_2_i == 2'd3);
            overrun_q <= per_fire && (state_q != IDLE);
        end
    end

    assign m_axis_out_tvalid = (state_q == RUN);
    assign m_axis_out_tlast  = (state_q == RUN) && (sym_cnt_q == LAST_SYM);
    assign m_axis_out_tdata  = (state_q == RUN) ? {{HW{1'b0}}, (lfsr_q[0] ? I_NEG : I_POS)} : '0;
    assign busy_o            = (state_q != IDLE);
    assign err_o             = err_q;
    assign overrun_o         = overrun_q;
endmodule

// File: tb/tb_pss_burst_gen.sv
// Directed bench for pss_burst_gen: sequence content, seed latency, backpressure, errors, periodic relaunch, async reset.
`timescale 1ns/1ps
module tb_pss_burst_gen;
    localparam logic [31:0] D_POS = 32'h0000_7FFF;
    localparam logic [31:0] D_NEG = 32'h0000_8001;

    logic        clk_i = 1'b0;
    logic        reset_i, start_i, periodic_en_i;
    logic [1:0]  N_id_2_i;
    logic [15:0] period_i;
    logic [31:0] m_axis_out_tdata;
    logic        m_axis_out_tvalid, m_axis_out_tready, m_axis_out_tlast;
    logic        busy_o, err_o, overrun_o;

    int n_checks = 0;
    int n_errors = 0;
    logic [133:0] xs;
    logic         x_ref [0:126];
    logic [31:0]  beat_data [0:126];
    logic [31:0]  first7 [0:6];
    int rise_q[$], tlast_q[$], ovr_q[$];

    pss_burst_gen dut (
        .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .N_id_2_i(N_id_2_i),
        .periodic_en_i(periodic_en_i), .period_i(period_i),
        .m_axis_out_tdata(m_axis_out_tdata), .m_axis_out_tvalid(m_axis_out_tvalid),
        .m_axis_out_tready(m_axis_out_tready), .m_axis_out_tlast(m_axis_out_tlast),
        .busy_o(busy_o), .err_o(err_o), .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_sym(input int nid, input int n);
        return x_ref[(n + 43*nid) % 127] ? D_NEG : D_POS;
    endfunction

    task automatic run_burst(input logic [1:0] nid, input bit rnd, input bit inject,
                             input int exp_lat, input string tag);
        int lat, cyc, beats, n_pos, n_neg, seq_err, last_err, stab_err, busy_err;
        logic [31:0] prev_d;
        logic prev_l;
        bit stalled;
        lat = 1; cyc = 0; beats = 0; n_pos = 0; n_neg = 0;
        seq_err = 0; last_err = 0; stab_err = 0; busy_err = 0;
        stalled = 1'b0; prev_d = '0; prev_l = 1'b0;
        start_i = 1'b1; N_id_2_i = nid; m_axis_out_tready = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        while (!m_axis_out_tvalid && lat < 200) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        while (beats < 127 && cyc < 2000) begin
            m_axis_out_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start_i = inject && (cyc == 30);
            if (inject && cyc == 30) N_id_2_i = 2'd2;
            if (!busy_o || !m_axis_out_tvalid) busy_err++;
            if (stalled && (m_axis_out_tdata !== prev_d || m_axis_out_tlast !== prev_l)) stab_err++;
            if (m_axis_out_tvalid && m_axis_out_tready) begin
                beat_data[beats] = m_axis_out_tdata;
                if (m_axis_out_tdata !== exp_sym(nid, beats)) seq_err++;
                if (m_axis_out_tdata == D_POS) n_pos++;
                else if (m_axis_out_tdata == D_NEG) n_neg++;
                if (m_axis_out_tlast !== (beats == 126)) last_err++;
                beats++;
            end
            stalled = m_axis_out_tvalid && !m_axis_out_tready;
            prev_d = m_axis_out_tdata;
            prev_l = m_axis_out_tlast;
            @(posedge clk_i); #1;
            cyc++;
        end
        start_i = 1'b0;
        m_axis_out_tready = 1'b1;
        check({tag, " beats"},     32'(beats),    32'd127);
        check({tag, " seq_err"},   32'(seq_err),  32'd0);
        check({tag, " tlast_err"}, 32'(last_err), 32'd0);
        check({tag, " stable"},    32'(stab_err), 32'd0);
        check({tag, " busy"},      32'(busy_err), 32'd0);
        check({tag, " n_pos"},     32'(n_pos),    32'd63);
        check({tag, " n_neg"},     32'(n_neg),    32'd64);
        check({tag, " tvalid_end"}, 32'(m_axis_out_tvalid), 32'd0);
        check({tag, " busy_end"},   32'(busy_o),            32'd0);
    endtask

    task automatic monitor(input int ncyc);
        logic prev_v;
        rise_q.delete(); tlast_q.delete(); ovr_q.delete();
        prev_v = m_axis_out_tvalid;
        for (int t = 1; t <= ncyc; t++) begin
            @(posedge clk_i); #1;
            start_i = 1'b0;
            if (m_axis_out_tvalid && !prev_v) rise_q.push_back(t);
            if (m_axis_out_tvalid && m_axis_out_tlast) tlast_q.push_back(t);
            if (overrun_o) ovr_q.push_back(t);
            prev_v = m_axis_out_tvalid;
        end
    endtask

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        while (busy_o && guard < 400) begin
            @(posedge clk_i); #1;
            guard++;
        end
        check({tag, " idle"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        xs = '0;
        xs[6:0] = 7'b1110110;
        for (int i = 0; i < 127; i++) begin
            xs[i+7] = xs[i+4] ^ xs[i];
            x_ref[i] = xs[i];
        end
        first7 = '{D_POS, D_NEG, D_NEG, D_POS, D_NEG, D_NEG, D_NEG};

        reset_i = 1'b1; start_i = 1'b0; N_id_2_i = 2'd0;
        periodic_en_i = 1'b0; period_i = 16'd0; m_axis_out_tready = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst tvalid",  32'(m_axis_out_tvalid), 32'd0);
        check("rst busy",    32'(busy_o),            32'd0);
        check("rst tdata",   m_axis_out_tdata,       32'd0);
        check("rst tlast",   32'(m_axis_out_tlast),  32'd0);
        check("rst err",     32'(err_o),             32'd0);
        check("rst overrun", 32'(overrun_o),         32'd0);
        #2 reset_i = 1'b0;
        @(posedge clk_i); #1;

        run_burst(2'd0, 1'b0, 1'b0, 1, "n0");
        for (int i = 0; i < 7; i++) check($sformatf("n0 first%0d", i), beat_data[i], first7[i]);
        run_burst(2'd1, 1'b0, 1'b0, 44, "n1");
        run_burst(2'd2, 1'b0, 1'b0, 87, "n2");
        run_burst(2'd0, 1'b1, 1'b0, 1, "bp0");
        run_burst(2'd2, 1'b1, 1'b0, 87, "bp2");
        run_burst(2'd0, 1'b0, 1'b1, 1, "midstart");

        start_i = 1'b1; N_id_2_i = 2'd3;
        @(posedge clk_i); #1;
        start_i = 1'b0; N_id_2_i = 2'd0;
        check("err pulse",   32'(err_o),             32'd1);
        check("err busy",    32'(busy_o),            32'd0);
        check("err tvalid",  32'(m_axis_out_tvalid), 32'd0);
        @(posedge clk_i); #1;
        check("err clear",   32'(err_o),             32'd0);
        monitor(100);
        check("err no burst", 32'(rise_q.size()), 32'd0);

        periodic_en_i = 1'b1; period_i = 16'd200; N_id_2_i = 2'd0; start_i = 1'b1;
        monitor(650);
        check("p200 rises", 32'(rise_q.size()), 32'd4);
        for (int i = 0; i < rise_q.size() && i < 4; i++)
            check($sformatf("p200 rise%0d", i), 32'(rise_q[i]), 32'(1 + 200*i));
        check("p200 overruns", 32'(ovr_q.size()), 32'd0);
        periodic_en_i = 1'b0;
        wait_idle("p200");

        period_i = 16'd100; periodic_en_i = 1'b1; start_i = 1'b1;
        monitor(500);
        check("p100 rises", 32'(rise_q.size()), 32'd4);
        for (int i = 0; i < rise_q.size() && i < 4; i++)
            check($sformatf("p100 rise%0d", i), 32'(rise_q[i]), 32'(1 + 128*i));
        check("p100 overruns", 32'(ovr_q.size()), 32'd4);
        for (int i = 0; i < ovr_q.size() && i < 4; i++)
            check($sformatf("p100 ovr%0d", i), 32'(ovr_q[i]), 32'(101 + 128*i));
        check("p100 tlasts", 32'(tlast_q.size()), 32'd3);
        for (int i = 0; i < tlast_q.size() && i < 3; i++)
            check($sformatf("p100 tlast%0d", i), 32'(tlast_q[i]), 32'(127 + 128*i));
        periodic_en_i = 1'b0;
        monitor(200);
        check("disable completes", 32'(tlast_q.size()), 32'd1);
        check("disable tlast at",  tlast_q.size() > 0 ? 32'(tlast_q[0]) : 32'd0, 32'd11);
        check("disable no relaunch", 32'(rise_q.size()), 32'd0);
        period_i = 16'd0;

        start_i = 1'b1; N_id_2_i = 2'd0; m_axis_out_tready = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (50) @(posedge clk_i);
        #1;
        check("pre-reset tvalid", 32'(m_axis_out_tvalid), 32'd1);
        #2 reset_i = 1'b1;
        #1;
        check("async tvalid", 32'(m_axis_out_tvalid), 32'd0);
        check("async busy",   32'(busy_o),            32'd0);
        check("async tdata",  m_axis_out_tdata,       32'd0);
        #2 reset_i = 1'b0;
        @(posedge clk_i); #1;
        check("post-reset tvalid", 32'(m_axis_out_tvalid), 32'd0);
        run_burst(2'd0, 1'b0, 1'b0, 1, "after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
